// File: rtl/sysbus_pkg.sv
// SysBus shared definitions: tag field layout, responder state encoding and
// block geometry. Imported by the memory responder and the core-side
// memory_controller.
package sysbus_pkg;

    // Tag layout: [12] write, [11:8] transaction type, [7:0] requester id
    localparam int TAG_WRITE_BIT = 12;
    localparam int TAG_TYPE_MSB  = 11;
    localparam int TAG_TYPE_LSB  = 8;
    localparam logic [3:0] TYPE_MEMORY = 4'h1;

    // Block geometry: 64-byte block = 8 beats of 64 bits
    localparam int BEATS          = 8;
    localparam int BEAT_IDX_W     = 3;
    localparam int WORD_OFFSET_W  = 3;   // byte offset inside one 64-bit word
    localparam int BLOCK_OFFSET_W = 6;   // byte offset inside one block

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RD_WAIT = 2'd1,
        ST_RD_BEAT = 2'd2,
        ST_WR_DATA = 2'd3
    } state_t;

    // Word slot inside the block for beat k when the burst starts at slot
    // 'start'; the 3-bit sum wraps inside the block.
    function automatic logic [BEAT_IDX_W-1:0] beat_word(
        input logic [BEAT_IDX_W-1:0] start,
        input logic [BEAT_IDX_W-1:0] k
    );
        return start + k;
    endfunction

endpackage

// File: rtl/sysbus_mem_array.sv
// Word-addressed memory behind the SysBus responder: synchronous writes from
// a backdoor preload port and the bus write path, combinational read port.
// When both writes hit the same word in one cycle the backdoor value lands.
module sysbus_mem_array #(
    parameter int DATA_W = 64,
    parameter int WORDS  = 4096,
    parameter int AW     = $clog2(WORDS)
) (
    input  logic              clk,
    input  logic              init_we,
    input  logic [AW-1:0]     init_addr,
    input  logic [DATA_W-1:0] init_data,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [AW-1:0]     rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [WORDS];

    // Write ports; the backdoor assignment comes last so it wins a collision
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (init_we) begin
            mem[init_addr] <= init_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/sysbus_mem_responder.sv
// SysBus memory responder: accepts one read or write block transaction at a
// time and serves 64-byte blocks as eight 64-bit beats from a local array.
// Optional build macro: CRITICAL_WORD_FIRST_EN starts read bursts at the
// addressed word and wraps inside the block; writes always fill words 0..7.
//
// Handshakes: a request (header or write beat) is offered with bus_reqcyc and
// taken in a cycle where the responder is able to accept and bus_reqack was
// low; bus_reqack then pulses for exactly the next cycle, and the requester
// moves on to its next item after seeing it. A response beat is offered with
// bus_respcyc and held with bus_resp/bus_resptag stable until a cycle with
// bus_respcyc && bus_respack; the next beat follows in the very next cycle.
module sysbus_mem_responder
    import sysbus_pkg::*;
#(
    parameter int BUS_DATA_WIDTH = 64,
    parameter int BUS_TAG_WIDTH  = 13,
    parameter int MEM_WORDS      = 4096,
    parameter int READ_LATENCY   = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         bus_reqcyc,
    input  logic [BUS_DATA_WIDTH-1:0]    bus_req,
    input  logic [BUS_TAG_WIDTH-1:0]     bus_reqtag,
    output logic                         bus_reqack,
    output logic                         bus_respcyc,
    output logic [BUS_DATA_WIDTH-1:0]    bus_resp,
    output logic [BUS_TAG_WIDTH-1:0]     bus_resptag,
    input  logic                         bus_respack,
    input  logic                         init_we,
    input  logic [$clog2(MEM_WORDS)-1:0] init_addr,
    input  logic [BUS_DATA_WIDTH-1:0]    init_data,
    output logic                         busy,
    output logic [1:0]                   state_dbg
);

    localparam int AW    = $clog2(MEM_WORDS);
    localparam int LAT_W = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;

    state_t state, state_next;

    logic [AW-1:0]             word_q;     // word index of the request address
    logic [BUS_TAG_WIDTH-1:0]  tag_q;
    logic                      drop_q;     // accepted header of a foreign type
    logic [BEAT_IDX_W-1:0]     beat_q;
    logic [LAT_W-1:0]          wait_cnt;

    logic                      reqack_q;
    logic                      respcyc_q;
    logic [BUS_DATA_WIDTH-1:0] resp_q;
    logic [BUS_TAG_WIDTH-1:0]  resptag_q;

    logic                      hdr_accept;
    logic                      wr_accept;
    logic                      resp_fire;
    logic                      wait_done;
    logic [BEAT_IDX_W-1:0]     start_idx;
    logic [BEAT_IDX_W-1:0]     rd_beat;
    logic [BEAT_IDX_W-1:0]     rd_idx;
    logic [AW-1:0]             block_base;
    logic [AW-1:0]             rd_addr;
    logic [AW-1:0]             wr_addr;
    logic [BUS_DATA_WIDTH-1:0] rd_data;

`ifdef CRITICAL_WORD_FIRST_EN
    assign start_idx = word_q[BEAT_IDX_W-1:0];
`else
    assign start_idx = '0;
`endif

    // A new item is never taken while the previous ack is still on the bus
    assign hdr_accept = (state == ST_IDLE) && bus_reqcyc && !reqack_q;
    assign wr_accept  = (state == ST_WR_DATA) && !drop_q && bus_reqcyc && !reqack_q;
    assign resp_fire  = (state == ST_RD_BEAT) && respcyc_q && bus_respack;
    assign wait_done  = (wait_cnt == LAT_W'(READ_LATENCY - 1));

    // Read port looks one beat ahead while a beat is on the bus, so the next
    // beat is fetched at the moment it is issued
    assign rd_beat    = (state == ST_RD_BEAT) ? beat_q + BEAT_IDX_W'(1) : beat_q;
    assign rd_idx     = beat_word(start_idx, rd_beat);
    assign block_base = word_q & ~AW'(BEATS - 1);
    assign rd_addr    = block_base | AW'(rd_idx);
    assign wr_addr    = block_base | AW'(beat_q);

    sysbus_mem_array #(
        .DATA_W (BUS_DATA_WIDTH),
        .WORDS  (MEM_WORDS),
        .AW     (AW)
    ) u_mem (
        .clk       (clk),
        .init_we   (init_we),
        .init_addr (init_addr),
        .init_data (init_data),
        .wr_en     (wr_accept),
        .wr_addr   (wr_addr),
        .wr_data   (bus_req),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data)
    );

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; a dropped header spends one cycle in its data state
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (hdr_accept) begin
                    state_next = bus_reqtag[TAG_WRITE_BIT] ? ST_WR_DATA : ST_RD_WAIT;
                end
            end
            ST_RD_WAIT: begin
                if (drop_q) begin
                    state_next = ST_IDLE;
                end else if (wait_done) begin
                    state_next = ST_RD_BEAT;
                end
            end
            ST_RD_BEAT: begin
                if (resp_fire && beat_q == BEAT_IDX_W'(BEATS - 1)) begin
                    state_next = ST_IDLE;
                end
            end
            ST_WR_DATA: begin
                if (drop_q) begin
                    state_next = ST_IDLE;
                end else if (wr_accept && beat_q == BEAT_IDX_W'(BEATS - 1)) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Request latch, beat/latency counters and registered bus outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            word_q    <= '0;
            tag_q     <= '0;
            drop_q    <= 1'b0;
            beat_q    <= '0;
            wait_cnt  <= '0;
            reqack_q  <= 1'b0;
            respcyc_q <= 1'b0;
            resp_q    <= '0;
            resptag_q <= '0;
        end else begin
            reqack_q <= hdr_accept || wr_accept;

            if (hdr_accept) begin
                word_q   <= bus_req[AW+WORD_OFFSET_W-1:WORD_OFFSET_W];
                tag_q    <= bus_reqtag;
                drop_q   <= (bus_reqtag[TAG_TYPE_MSB:TAG_TYPE_LSB] != TYPE_MEMORY);
                beat_q   <= '0;
                wait_cnt <= '0;
            end

            if (state == ST_RD_WAIT && !wait_done) begin
                wait_cnt <= wait_cnt + LAT_W'(1);
            end

            if (state == ST_RD_WAIT && !drop_q && wait_done) begin
                respcyc_q <= 1'b1;
                resp_q    <= rd_data;
                resptag_q <= tag_q;
            end

            if (resp_fire) begin
                if (beat_q == BEAT_IDX_W'(BEATS - 1)) begin
                    respcyc_q <= 1'b0;
                end else begin
                    beat_q <= beat_q + BEAT_IDX_W'(1);
                    resp_q <= rd_data;
                end
            end

            if (wr_accept) begin
                beat_q <= beat_q + BEAT_IDX_W'(1);
            end
        end
    end

    assign bus_reqack  = reqack_q;
    assign bus_respcyc = respcyc_q;
    assign bus_resp    = resp_q;
    assign bus_resptag = resptag_q;
    assign busy        = (state != ST_IDLE);
    assign state_dbg   = state;

endmodule

// File: tb/tb_sysbus_mem_responder.sv
// Bench for sysbus_mem_responder: table of read transactions checked against
// a word model and an expected-beat queue, plus hand-written write, foreign
// type and mid-burst reset sequences.
module tb_sysbus_mem_responder;

    localparam int MEM_WORDS    = 4096;
    localparam int AW           = 12;
    localparam int READ_LATENCY = 4;

    logic        clk;
    logic        reset;
    logic        bus_reqcyc;
    logic [63:0] bus_req;
    logic [12:0] bus_reqtag;
    logic        bus_reqack;
    logic        bus_respcyc;
    logic [63:0] bus_resp;
    logic [12:0] bus_resptag;
    logic        bus_respack;
    logic        init_we;
    logic [AW-1:0] init_addr;
    logic [63:0] init_data;
    logic        busy;
    logic [1:0]  state_dbg;

    sysbus_mem_responder #(
        .BUS_DATA_WIDTH (64),
        .BUS_TAG_WIDTH  (13),
        .MEM_WORDS      (MEM_WORDS),
        .READ_LATENCY   (READ_LATENCY)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .bus_reqcyc  (bus_reqcyc),
        .bus_req     (bus_req),
        .bus_reqtag  (bus_reqtag),
        .bus_reqack  (bus_reqack),
        .bus_respcyc (bus_respcyc),
        .bus_resp    (bus_resp),
        .bus_resptag (bus_resptag),
        .bus_respack (bus_respack),
        .init_we     (init_we),
        .init_addr   (init_addr),
        .init_data   (init_data),
        .busy        (busy),
        .state_dbg   (state_dbg)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard state ----------------
    int          tests_run;
    int          tests_failed;
    logic [63:0] exp_q[$];
    logic [63:0] model [MEM_WORDS];
    int          ack_cnt;
    logic        prev_ack;

    typedef struct {
        logic [63:0] addr;
        logic [12:0] tag;
        int          mode;      // 0: respack high, 1: toggling, 2: random
        bit          bd_en;     // backdoor write during the read wait
        logic [11:0] bd_word;
        logic [63:0] bd_data;
        int          exp_lat;   // cycles from reqack to first respcyc
        logic [12:0] exp_tag;
    } rd_vec_t;

    rd_vec_t vecs [9];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // reqack must always be a single-cycle pulse
    always @(negedge clk) begin
        if (bus_reqack) begin
            ack_cnt++;
            check("reqack_single_cycle", 64'(prev_ack), 64'd0);
        end
        prev_ack = bus_reqack;
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [AW-1:0] addr, input logic [63:0] data);
        init_we   = 1'b1;
        init_addr = addr;
        init_data = data;
        model[addr] = data;
        step();
        init_we = 1'b0;
    endtask

    // Offer one request item and wait for its ack; lat = cycles after offer
    task automatic send_req(input logic [63:0] data, input logic [12:0] tag, output int lat);
        bit got;
        bus_req    = data;
        bus_reqtag = tag;
        bus_reqcyc = 1'b1;
        lat = 0;
        got = 1'b0;
        while (!got && lat < 16) begin
            @(negedge clk);
            if (bus_reqack) begin
                got = 1'b1;
            end else begin
                lat++;
                step();
            end
        end
        if (!got) check("reqack_timeout", 64'd0, 64'd1);
        step();
        bus_reqcyc = 1'b0;
    endtask

    task automatic run_read(input rd_vec_t v);
        int          lat;
        int          cyc;
        int          beats;
        int          first;
        bit          held;
        logic [63:0] stash;
        logic [63:0] e;
        logic [2:0]  start;
        logic [2:0]  idx;
        logic [11:0] base;

        bus_respack = 1'b0;
        send_req(v.addr, v.tag, lat);
        check("rd_hdr_ack_lat", 64'(lat), 64'd1);
        if (v.bd_en) begin
            init_we   = 1'b1;
            init_addr = v.bd_word;
            init_data = v.bd_data;
            model[v.bd_word] = v.bd_data;
        end

        base = v.addr[14:3] & 12'hFF8;
`ifdef CRITICAL_WORD_FIRST_EN
        start = v.addr[5:3];
`else
        start = 3'd0;
`endif
        for (int k = 0; k < 8; k++) begin
            idx = start + 3'(k);
            exp_q.push_back(model[base | {9'd0, idx}]);
        end

        cyc   = 1;
        beats = 0;
        first = -1;
        held  = 1'b0;
        stash = '0;
        while (beats < 8 && cyc < 100) begin
            case (v.mode)
                0:       bus_respack = 1'b1;
                1:       bus_respack = cyc[0];
                default: bus_respack = 1'($urandom_range(0, 1));
            endcase
            @(negedge clk);
            if (held) begin
                check("resp_hold_valid", 64'(bus_respcyc), 64'd1);
                check("resp_hold_data", bus_resp, stash);
                held = 1'b0;
            end
            if (bus_respcyc && first < 0) begin
                first = cyc;
                check("first_beat_latency", 64'(first), 64'(v.exp_lat));
                check("resptag", 64'(bus_resptag), 64'(v.exp_tag));
            end
            if (bus_respcyc && bus_respack) begin
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("read_beat", bus_resp, e);
                end else begin
                    check("read_beat_extra", 64'd1, 64'd0);
                end
                beats++;
            end else if (bus_respcyc) begin
                held  = 1'b1;
                stash = bus_resp;
            end
            step();
            init_we = 1'b0;
            cyc++;
        end
        if (beats < 8) check("read_beats_timeout", 64'(beats), 64'd8);
        bus_respack = 1'b1;
        @(negedge clk);
        check("respcyc_after_burst", 64'(bus_respcyc), 64'd0);
        check("busy_after_burst", 64'(busy), 64'd0);
        check("exp_q_drained", 64'(exp_q.size()), 64'd0);
        exp_q.delete();
        step();
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int          lat;
        int          a0;
        int          n_resp;
        int          beats;
        int          guard;
        logic [63:0] d;

        tests_run    = 0;
        tests_failed = 0;
        ack_cnt      = 0;
        prev_ack     = 1'b0;
        reset        = 1'b1;
        bus_reqcyc   = 1'b0;
        bus_req      = '0;
        bus_reqtag   = '0;
        bus_respack  = 1'b0;
        init_we      = 1'b0;
        init_addr    = '0;
        init_data    = '0;

        vecs[0] = '{64'h200,  13'h0103, 0, 1'b0, 12'h000, 64'h0,  4, 13'h0103};
        vecs[1] = '{64'h200,  13'h0103, 1, 1'b0, 12'h000, 64'h0,  4, 13'h0103};
        vecs[2] = '{64'h228,  13'h0177, 0, 1'b0, 12'h000, 64'h0,  4, 13'h0177};
        vecs[3] = '{64'h238,  13'h01FF, 1, 1'b0, 12'h000, 64'h0,  4, 13'h01FF};
        vecs[4] = '{64'h8200, 13'h0142, 0, 1'b0, 12'h000, 64'h0,  4, 13'h0142};
        vecs[5] = '{64'h1000, 13'h0105, 0, 1'b0, 12'h000, 64'h0,  4, 13'h0105};
        vecs[6] = '{64'h1030, 13'h0106, 1, 1'b0, 12'h000, 64'h0,  4, 13'h0106};
        vecs[7] = '{64'h200,  13'h0107, 0, 1'b1, 12'h045, 64'hBB, 4, 13'h0107};
        vecs[8] = '{64'h218,  13'h01A0, 2, 1'b0, 12'h000, 64'h0,  4, 13'h01A0};

        // reset values
        step();
        step();
        @(negedge clk);
        check("reset_reqack", 64'(bus_reqack), 64'd0);
        check("reset_respcyc", 64'(bus_respcyc), 64'd0);
        check("reset_resp", bus_resp, 64'd0);
        check("reset_resptag", 64'(bus_resptag), 64'd0);
        check("reset_busy", 64'(busy), 64'd0);
        step();
        reset = 1'b0;
        step();

        // preload block at word 0x40
        for (int k = 0; k < 8; k++) begin
            preload(12'h040 + 12'(k), 64'hA0 + 64'(k));
        end

        // block write to 0x1000 (words 0x200..0x207)
        a0 = ack_cnt;
        send_req(64'h1000, 13'h1105, lat);
        check("wr_hdr_ack_lat", 64'(lat), 64'd1);
        for (int k = 0; k < 8; k++) begin
            d = 64'h11 * 64'(k + 1);
            send_req(d, 13'h1105, lat);
            check("wr_beat_ack_lat", 64'(lat), 64'd1);
            model[12'h200 + 12'(k)] = d;
        end
        @(negedge clk);
        check("wr_busy_done", 64'(busy), 64'd0);
        check("wr_ack_count", 64'(ack_cnt - a0), 64'd9);
        step();

        // table-driven reads
        for (int i = 0; i < 9; i++) begin
            run_read(vecs[i]);
        end

        // foreign transaction type: acked once, dropped
        a0 = ack_cnt;
        send_req(64'h200, 13'h0203, lat);
        check("drop_ack_lat", 64'(lat), 64'd1);
        @(negedge clk);
        check("drop_busy_cleared", 64'(busy), 64'd0);
        n_resp = 0;
        for (int c = 0; c < 20; c++) begin
            step();
            @(negedge clk);
            if (bus_respcyc) n_resp++;
        end
        check("drop_no_response", 64'(n_resp), 64'd0);
        check("drop_ack_count", 64'(ack_cnt - a0), 64'd1);
        step();

        // reset after the third beat of a read burst
        bus_respack = 1'b1;
        send_req(64'h200, 13'h0103, lat);
        beats = 0;
        guard = 0;
        while (beats < 3 && guard < 50) begin
            @(negedge clk);
            if (bus_respcyc && bus_respack) begin
                check("pre_reset_beat", bus_resp, model[12'h040 + 12'(beats)]);
                beats++;
            end
            guard++;
            step();
        end
        check("pre_reset_beats", 64'(beats), 64'd3);
        reset = 1'b1;
        step();
        @(negedge clk);
        check("abort_respcyc", 64'(bus_respcyc), 64'd0);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_reqack", 64'(bus_reqack), 64'd0);
        check("abort_resp", bus_resp, 64'd0);
        check("abort_resptag", 64'(bus_resptag), 64'd0);
        step();
        reset = 1'b0;
        n_resp = 0;
        for (int c = 0; c < 10; c++) begin
            step();
            @(negedge clk);
            if (bus_respcyc) n_resp++;
        end
        check("abort_stays_quiet", 64'(n_resp), 64'd0);
        step();
        run_read(vecs[0]);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/sysbus_mem_responder.md
Name: sysbus_mem_responder

Overview:
Responder end of the 64-bit SysBus used by the core's memory_controller. It accepts read and write requests and returns 64-byte blocks as eight 64-bit beats from an internal word-addressed memory array. It serves as the bench/simulation memory behind the core's bus port, and as the template for a future cache-side responder. It handles one transaction at a time; while busy, new requests are not acknowledged.

Parameters:
BUS_DATA_WIDTH, 64, bus beat width (fixed at 64; other values unsupported)
BUS_TAG_WIDTH, 13, tag width
MEM_WORDS, 4096, depth of the 64-bit memory array (power of 2, >= 8)
READ_LATENCY, 4, cycles from read accept (reqack) to first respcyc (>= 1)
BEATS, 8, beats per block

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
bus_reqcyc  in  1  request valid (header or write-data beat)
bus_req  in  64  byte address on header; data on write beats
bus_reqtag  in  13  [12]=write, [11:8]=type, [7:0]=id
bus_reqack  out  1  one-cycle accept of a header or write beat
bus_respcyc  out  1  response beat valid
bus_resp  out  64  response data
bus_resptag  out  13  echo of the accepted request tag
bus_respack  in  1  requester consumes the current beat
init_we  in  1  backdoor preload write enable
init_addr  in  log2(MEM_WORDS)  backdoor word index
init_data  in  64  backdoor data
busy  out  1  high whenever state != IDLE

Behaviour:
- Reset: the state goes to IDLE and every output goes to 0: reqack, respcyc, resp, resptag, busy. Memory contents are preserved. Reset in mid-transaction aborts it with no further beats or acks.
- Word index: (addr[63:3] mod MEM_WORDS). The block base is addr with bits [5:0] cleared. Addresses wrap modulo the array size.
- States: IDLE, RD_WAIT, RD_BEAT, WR_DATA.
- IDLE: if reqcyc is high, assert reqack for exactly the next cycle, latch the address and tag, and set busy.
  - tag[11:8] != MEMORY (4'h1): the request is acked and dropped; return to IDLE.
  - Write bit = 0: go to RD_WAIT.
  - Write bit = 1: go to WR_DATA.
- RD_WAIT: count READ_LATENCY-1 cycles, then go to RD_BEAT with respcyc=1, beat 0 on bus_resp, and the latched tag on resptag.
- RD_BEAT: hold resp/respcyc stable until a cycle with respcyc && respack. The next beat is presented in the following cycle; no gaps if respack stays high. After the beat-7 handshake, drop respcyc in the next cycle and return to IDLE.
- WR_DATA: each cycle with reqcyc high, the beat is written to block word k (k = 0..7) and reqack is pulsed in the next cycle. After 8 beats, return to IDLE. Writes produce no response.
- reqack is never high for two consecutive cycles, so the requester must re-present reqcyc after each ack.
- Back-to-back transactions: a header may be accepted in the cycle after returning to IDLE.
- Backdoor: init_we writes init_data in the same cycle regardless of state. If it collides with a bus write to the same word, init wins.
- Read data is taken from the array at beat-issue time, so a backdoor write during RD_WAIT is visible.

Optional Feature:
CRITICAL_WORD_FIRST_EN:
- Defined: read beat order starts at word addr[5:3] and wraps within the block (e.g. start 5: 5,6,7,0,1,2,3,4).
- Undefined: beats are always issued 0..7 and addr[5:3] is ignored.
- Writes always fill 0..7 in either case.

Decomposition:
- Package sysbus_pkg: tag field constants (TAG_WRITE_BIT=12, TAG_TYPE_MSB/LSB, TYPE_MEMORY=4'h1), the state enum, BEATS, and the offset-width localparams. The core-side memory_controller imports the same package.
- Sub-module sysbus_mem_array: synchronous 64-bit RAM with two write ports (init has priority) and one combinational read port.

Test Plan:
- Preload words 0x40..0x47 with 0xA0..0xA7. Read header addr 0x200, tag 0x0103, respack held high → reqack 1 cycle after the header; respcyc starts 4 cycles after reqack; beats 0xA0..0xA7 on consecutive cycles; resptag=0x0103; then busy=0.
- Same read, with respack toggling every other cycle → each beat is held until acked; 8 beats total; no beat is skipped or duplicated.
- Write header addr 0x1000, tag 0x1105, then 8 beats 0x11..0x88 → 9 reqack pulses. A subsequent read of 0x1000 returns 0x11..0x88.
- With CRITICAL_WORD_FIRST_EN defined, read addr 0x228 → beat order 0xA5,0xA6,0xA7,0xA0..0xA4.
- Assert reset after the 3rd read beat → respcyc=0 the next cycle and stays 0. The next read of the same block returns the full 8 beats correctly.
- Header with tag 0x0203 (type 2) → one reqack, no respcyc within 20 cycles, busy back to 0 after 2 cycles.
